// File: rtl/merge_ctrl_n.sv
// Two-way run merger: merges zero-terminated runs from FIFO heads A and B into one output register.
// Optional run counter port o_run_cnt is built only with MERGE_RUN_COUNT_EN defined.
module merge_ctrl_n #(
    parameter int DATA_W  = 32,
    parameter int DESCEND = 0,
    parameter int CNT_W   = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_a_data,
    input  logic [DATA_W-1:0] i_b_data,
    input  logic              i_a_valid,
    input  logic              i_b_valid,
    input  logic              i_a_eos,
    input  logic              i_b_eos,
    output logic              o_a_pop,
    output logic              o_b_pop,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_run_end,
    output logic              o_done,
    output logic              o_err
`ifdef MERGE_RUN_COUNT_EN
    ,
    output logic [CNT_W-1:0]  o_run_cnt
`endif
);

    typedef enum logic [1:0] {MERGE, DRAIN_A, DRAIN_B, DONE} state_t;

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   data_p1;
    logic                run_end_p1;
    logic                vld_p1;
    logic                err_q;

    logic                slot_free, both_zero, a_zero, b_zero;
    logic                load, term, err_set;
    logic [DATA_W-1:0]   sel_data;

    // Ties go to A; unsigned compare over the full record width.
    function automatic logic take_a(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        if (DESCEND != 0)
            return a >= b;
        else
            return a <= b;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign a_zero    = (i_a_data == '0);
    assign b_zero    = (i_b_data == '0);
    assign slot_free = ~vld_p1 | i_ready;
    assign both_zero = i_a_valid & i_b_valid & a_zero & b_zero;

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        term      = 1'b0;
        err_set   = 1'b0;
        o_a_pop   = 1'b0;
        o_b_pop   = 1'b0;
        sel_data  = '0;

        if (slot_free && !i_rst && state != DONE) begin
            if (both_zero) begin
                term    = 1'b1;
                load    = 1'b1;
                o_a_pop = 1'b1;
                o_b_pop = 1'b1;
                if (i_a_eos && i_b_eos) begin
                    state_nxt = DONE;
                end else if (!i_a_eos && !i_b_eos) begin
                    state_nxt = MERGE;
                end else begin
                    err_set   = 1'b1;
                    state_nxt = DONE;
                end
            end else begin
                case (state)
                    MERGE: begin
                        if (i_a_valid && i_b_valid) begin
                            load = 1'b1;
                            if (a_zero) begin
                                o_b_pop   = 1'b1;
                                sel_data  = i_b_data;
                                state_nxt = DRAIN_B;
                            end else if (b_zero) begin
                                o_a_pop   = 1'b1;
                                sel_data  = i_a_data;
                                state_nxt = DRAIN_A;
                            end else if (take_a(i_a_data, i_b_data)) begin
                                o_a_pop  = 1'b1;
                                sel_data = i_a_data;
                            end else begin
                                o_b_pop  = 1'b1;
                                sel_data = i_b_data;
                            end
                        end
                    end
                    DRAIN_A: begin
                        if (i_a_valid && !a_zero) begin
                            load     = 1'b1;
                            o_a_pop  = 1'b1;
                            sel_data = i_a_data;
                        end
                    end
                    DRAIN_B: begin
                        if (i_b_valid && !b_zero) begin
                            load     = 1'b1;
                            o_b_pop  = 1'b1;
                            sel_data = i_b_data;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // p1: single output register stage
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= MERGE;
            vld_p1     <= 1'b0;
            data_p1    <= '0;
            run_end_p1 <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load) begin
                vld_p1     <= 1'b1;
                data_p1    <= sel_data;
                run_end_p1 <= term;
            end else if (i_ready) begin
                vld_p1 <= 1'b0;
            end
            if (err_set)
                err_q <= 1'b1;
        end
    end

`ifdef MERGE_RUN_COUNT_EN
    logic [CNT_W-1:0] run_cnt_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            run_cnt_q <= '0;
        else if (term)
            run_cnt_q <= sat_inc(run_cnt_q);
    end

    assign o_run_cnt = run_cnt_q;
`endif

    assign o_data    = data_p1;
    assign o_valid   = vld_p1;
    assign o_run_end = run_end_p1;
    assign o_done    = (state == DONE);
    assign o_err     = err_q;

endmodule

// File: tb/tb_merge_ctrl_n.sv
// Randomized bench for merge_ctrl_n: two instances (ascending, descending) checked against a list-merge model.
module tb_merge_ctrl_n;
    localparam int DW = 8;
    localparam int CW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [DW-1:0] a_data[2], b_data[2], o_data[2];
    logic          a_valid[2], b_valid[2], a_eos[2], b_eos[2];
    logic          a_pop[2], b_pop[2], o_valid[2], ready[2];
    logic          o_run_end[2], o_done[2], o_err[2];
`ifdef MERGE_RUN_COUNT_EN
    logic [CW-1:0] run_cnt[2];
`endif

    merge_ctrl_n #(.DATA_W(DW), .DESCEND(0), .CNT_W(CW)) u_asc (
        .i_clk(clk), .i_rst(rst),
        .i_a_data(a_data[0]), .i_b_data(b_data[0]),
        .i_a_valid(a_valid[0]), .i_b_valid(b_valid[0]),
        .i_a_eos(a_eos[0]), .i_b_eos(b_eos[0]),
        .o_a_pop(a_pop[0]), .o_b_pop(b_pop[0]),
        .o_data(o_data[0]), .o_valid(o_valid[0]), .i_ready(ready[0]),
        .o_run_end(o_run_end[0]), .o_done(o_done[0]), .o_err(o_err[0])
`ifdef MERGE_RUN_COUNT_EN
        , .o_run_cnt(run_cnt[0])
`endif
    );

    merge_ctrl_n #(.DATA_W(DW), .DESCEND(1), .CNT_W(CW)) u_dsc (
        .i_clk(clk), .i_rst(rst),
        .i_a_data(a_data[1]), .i_b_data(b_data[1]),
        .i_a_valid(a_valid[1]), .i_b_valid(b_valid[1]),
        .i_a_eos(a_eos[1]), .i_b_eos(b_eos[1]),
        .o_a_pop(a_pop[1]), .o_b_pop(b_pop[1]),
        .o_data(o_data[1]), .o_valid(o_valid[1]), .i_ready(ready[1]),
        .o_run_end(o_run_end[1]), .o_done(o_done[1]), .o_err(o_err[1])
`ifdef MERGE_RUN_COUNT_EN
        , .o_run_cnt(run_cnt[1])
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // FIFO contents (bit 8 = eos) and expected output stream (bit 8 = run_end)
    logic [8:0] qa[$], qb[$], qe[$];
    int         ra[$], rb[$];
    int         exp_terms;
    logic       exp_err;

    // Append one run to each FIFO and the stably merged result plus terminator to the expectation.
    task automatic add_run(input int d, input bit ea, input bit eb);
        int i = 0;
        int j = 0;
        bit ta;
        foreach (ra[k]) qa.push_back({1'b0, 8'(ra[k])});
        foreach (rb[k]) qb.push_back({1'b0, 8'(rb[k])});
        qa.push_back({ea, 8'h00});
        qb.push_back({eb, 8'h00});
        while (i < ra.size() || j < rb.size()) begin
            if (j >= rb.size()) ta = 1'b1;
            else if (i >= ra.size()) ta = 1'b0;
            else ta = (d != 0) ? (ra[i] >= rb[j]) : (ra[i] <= rb[j]);
            if (ta) begin qe.push_back({1'b0, 8'(ra[i])}); i++; end
            else    begin qe.push_back({1'b0, 8'(rb[j])}); j++; end
        end
        qe.push_back(9'h100);
        exp_terms++;
        if (ea != eb) exp_err = 1'b1;
        ra.delete();
        rb.delete();
    endtask

    task automatic gen_run(input int d, input bit ea, input bit eb);
        int la = $urandom_range(0, 4);
        int lb = $urandom_range(0, 4);
        for (int k = 0; k < la; k++) ra.push_back($urandom_range(1, 255));
        for (int k = 0; k < lb; k++) rb.push_back($urandom_range(1, 255));
        if (d != 0) begin ra.rsort(); rb.rsort(); end
        else        begin ra.sort();  rb.sort();  end
        add_run(d, ea, eb);
    endtask

    task automatic drive_idle();
        for (int k = 0; k < 2; k++) begin
            a_valid[k] = 1'b0; b_valid[k] = 1'b0;
            a_data[k]  = '0;   b_data[k]  = '0;
            a_eos[k]   = 1'b0; b_eos[k]   = 1'b0;
            ready[k]   = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        qa.delete(); qb.delete(); qe.delete(); ra.delete(); rb.delete();
        exp_terms = 0;
        exp_err   = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_zero(input int d, input string tag);
        chk({tag, "_valid"},   32'(o_valid[d]),   0);
        chk({tag, "_data"},    32'(o_data[d]),    0);
        chk({tag, "_run_end"}, 32'(o_run_end[d]), 0);
        chk({tag, "_done"},    32'(o_done[d]),    0);
        chk({tag, "_err"},     32'(o_err[d]),     0);
        chk({tag, "_popa"},    32'(a_pop[d]),     0);
        chk({tag, "_popb"},    32'(b_pop[d]),     0);
`ifdef MERGE_RUN_COUNT_EN
        chk({tag, "_cnt"},     32'(run_cnt[d]),   0);
`endif
    endtask

    // mode 0: random gaps/backpressure; 1: always ready; 2: ready low 3 cycles on first output
    task automatic run_scn(input int d, input int mode);
        int         n_out = 0;
        int         stall = 0;
        int         cyc   = 0;
        int         idle  = 0;
        logic       pa, pb, acc, prev_stall;
        logic [9:0] prev_v, cur_v;
        logic [8:0] e;
        prev_stall = 1'b0;
        prev_v     = '0;
        @(posedge clk); #1;
        while (cyc < 2000 && idle < 6) begin
            a_valid[d] = (qa.size() > 0) && (mode != 0 || $urandom_range(0, 3) != 0);
            a_data[d]  = (qa.size() > 0) ? qa[0][7:0] : '0;
            a_eos[d]   = (qa.size() > 0) ? qa[0][8] : 1'b0;
            b_valid[d] = (qb.size() > 0) && (mode != 0 || $urandom_range(0, 3) != 0);
            b_data[d]  = (qb.size() > 0) ? qb[0][7:0] : '0;
            b_eos[d]   = (qb.size() > 0) ? qb[0][8] : 1'b0;
            if (mode == 0) ready[d] = ($urandom_range(0, 3) != 0);
            else if (mode == 2 && o_valid[d] && n_out == 0 && stall < 3) begin
                ready[d] = 1'b0;
                stall++;
            end else ready[d] = 1'b1;

            @(negedge clk);
            pa    = a_pop[d];
            pb    = b_pop[d];
            acc   = o_valid[d] & ready[d];
            cur_v = {o_valid[d], o_run_end[d], o_data[d]};
            if (prev_stall) chk("hold", 32'(cur_v), 32'(prev_v));
            prev_stall = o_valid[d] & ~ready[d];
            prev_v     = cur_v;
            if (pa) begin
                chk("popa_head", 32'(a_valid[d]), 1);
                chk("popa_slot", 32'(o_valid[d] & ~ready[d]), 0);
            end
            if (pb) begin
                chk("popb_head", 32'(b_valid[d]), 1);
                chk("popb_slot", 32'(o_valid[d] & ~ready[d]), 0);
            end
            if (qe.size() == 0) begin
                chk("popa_after_done", 32'(pa), 0);
                chk("popb_after_done", 32'(pb), 0);
                idle++;
            end

            @(posedge clk); #1;
            if (pa && qa.size() > 0) void'(qa.pop_front());
            if (pb && qb.size() > 0) void'(qb.pop_front());
            if (acc) begin
                if (qe.size() == 0) chk("extra_out", 1, 0);
                else begin
                    e = qe.pop_front();
                    chk("data",    32'(cur_v[7:0]), 32'(e[7:0]));
                    chk("run_end", 32'(cur_v[8]),   32'(e[8]));
                    n_out++;
                end
            end
            cyc++;
        end
        chk("outputs_left", qe.size(), 0);
        chk("qa_left", qa.size(), 0);
        chk("qb_left", qb.size(), 0);
        chk("done", 32'(o_done[d]), 1);
        chk("err",  32'(o_err[d]),  32'(exp_err));
`ifdef MERGE_RUN_COUNT_EN
        chk("run_cnt", 32'(run_cnt[d]), (exp_terms > 3) ? 3 : exp_terms);
`endif
    endtask

    initial begin
        int  n;
        bit  bad;
        rst = 1'b1;
        drive_idle();
        exp_terms = 0;
        exp_err   = 1'b0;
        #1;
        chk_zero(0, "rst_asc");
        chk_zero(1, "rst_dsc");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // A=3,7,0(eos) B=5,0(eos)
        do_reset();
        ra = '{3, 7}; rb = '{5};
        add_run(0, 1'b1, 1'b1);
        run_scn(0, 1);

        // same with backpressure on the first output
        do_reset();
        ra = '{3, 7}; rb = '{5};
        add_run(0, 1'b1, 1'b1);
        run_scn(0, 2);

        // descending with a tie, then a closing run proving return to MERGE
        do_reset();
        ra = '{9, 4}; rb = '{9, 2};
        add_run(1, 1'b0, 1'b0);
        ra = '{8}; rb = '{3};
        add_run(1, 1'b1, 1'b1);
        run_scn(1, 1);

        // eos mismatch
        do_reset();
        add_run(0, 1'b1, 1'b0);
        run_scn(0, 1);

        // A valid, B empty: nothing moves until B arrives
        do_reset();
        @(posedge clk); #1;
        a_valid[0] = 1'b1; a_data[0] = 8'd4; ready[0] = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("b_empty_valid", 32'(o_valid[0]), 0);
            chk("b_empty_popa",  32'(a_pop[0]),   0);
        end
        b_valid[0] = 1'b1; b_data[0] = 8'd6;
        @(negedge clk);
        chk("b_arrive_popa", 32'(a_pop[0]), 1);
        chk("b_arrive_popb", 32'(b_pop[0]), 0);
        @(posedge clk); #1;
        chk("b_arrive_data", 32'(o_data[0]), 4);

        // reset while holding an output in DRAIN_B
        do_reset();
        @(posedge clk); #1;
        a_valid[0] = 1'b1; a_data[0] = 8'd0;
        b_valid[0] = 1'b1; b_data[0] = 8'd5;
        ready[0]   = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_valid", 32'(o_valid[0]), 1);
        chk("pre_rst_data",  32'(o_data[0]),  5);
        #2;
        rst = 1'b1;
        #1;
        chk_zero(0, "async_rst");
        drive_idle();

        // random scenarios on both orderings
        for (int it = 0; it < 24; it++) begin
            int d = it % 2;
            do_reset();
            n   = $urandom_range(1, 5);
            bad = ($urandom_range(0, 3) == 0);
            for (int r = 0; r < n; r++) begin
                if (r == n - 1) gen_run(d, 1'b1, !bad);
                else            gen_run(d, 1'b0, 1'b0);
            end
            run_scn(d, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
